rob: RTL and testbench
======================

Name: rob

Overview:
- Reorder buffer for the Tomasulo core. It is the counterpart of the rename register file.
- Hands out ROB names at issue.
- Answers the register file's operand-order lookups with ready/value.
- Captures CDB results and retires entries in program order.
- Drives the commit port that the register file consumes.

Parameters:
- ROB_SIZE, 16, number of entries; power of two; index width = log2(ROB_SIZE) (matches `ROBID).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- rdy  in  1  global enable; low = hold all state
- clr  in  1  flush (mispredict); discard all entries
- IS_sgn  in  1  allocate an entry this cycle
- IS_rd  in  `REGID  destination register of issuing instruction
- ROB_full  out  1  no free entry; issue must stall
- ROB_name  out  `ROBID  name of the entry the next issue takes (current tail)
- ROB_ord1  in  `ROBID  lookup index 1 (from register file)
- ROB_ord2  in  `ROBID  lookup index 2
- ROB_rdy1  out  1  entry ord1 holds a valid result
- ROB_rdy2  out  1  entry ord2 holds a valid result
- ROB_val1  out  32  result of entry ord1
- ROB_val2  out  32  result of entry ord2
- CDB_sgn  in  1  result broadcast valid
- CDB_name  in  `ROBID  producing entry
- CDB_val  in  32  result value
- ROB_commit_sgn  out  1  registered one-cycle commit pulse
- ROB_commit_dest  out  `REGID  committed destination register
- ROB_commit_value  out  32  committed value
- ROB_commit_ROB_name  out  `ROBID  committed entry name

Behaviour:
- State:
  - head, tail: `ROBID.
  - count: 0..ROB_SIZE (index width + 1 bits).
  - Per entry: busy, ready, dest[4:0], value[31:0].
- Reset (rst=1 at posedge):
  - head=tail=count=0; all busy/ready=0.
  - ROB_commit_sgn=0; commit dest/value/name=0.
- Combinational outputs:
  - ROB_full = (count==ROB_SIZE).
  - ROB_name = tail.
  - ROB_rdyN = busy[ordN] && (ready[ordN] || (CDB_sgn && CDB_name==ordN)).
  - ROB_valN = CDB_val when the CDB bypass hits, else value[ordN]; 0 when not ready.
- When rdy=0: no state changes, and ROB_commit_sgn is forced 0 at the next edge.
- Issue (posedge, rdy, !clr, IS_sgn, !ROB_full):
  - entry[tail] gets busy=1, ready=0, dest=IS_rd.
  - tail = tail+1 (mod ROB_SIZE, natural wrap).
  - IS_sgn while full is ignored; no state change.
- Writeback (posedge, rdy, CDB_sgn, busy[CDB_name]):
  - ready=1, value=CDB_val.
  - A CDB to a non-busy entry is ignored.
- Commit (posedge, rdy, !clr, busy[head] && ready[head]):
  - ROB_commit_sgn=1, with dest/value/name taken from entry[head].
  - busy[head]=0; head = head+1.
  - Otherwise ROB_commit_sgn=0. At most one commit per cycle.
- Latency:
  - A CDB write at edge N makes the entry committable at edge N+1; the commit pulse is visible in cycle N+1.
  - The lookup bypass means a same-cycle CDB result is visible to operand reads with zero latency.
- count:
  - issue only: +1; commit only: −1; issue and commit together: unchanged.
  - Issue into a full ROB is accepted in the same cycle as a commit only if count<ROB_SIZE at the start of the cycle. No bypass of freed slots.
- dest==0 entries:
  - Still retire and pulse ROB_commit_sgn with dest=0.
  - The register file must treat x0 as a no-op.
- Flush (clr=1 at posedge with rdy):
  - All busy/ready=0; head=tail=count=0; ROB_commit_sgn=0.
  - Issue and commit in that cycle are dropped. rst has priority over clr.
- Wrap-around: pointers roll ROB_SIZE−1 → 0 with no special case; lookups index by physical entry.

Decomposition:
- Shared defines.v holds `ROBID, `REGID, `True/`False, and ROB_SIZE as a `define used by both REG and rob.
- No sub-module. Entry arrays and pointer logic are in a single module.

Test Plan:
- Reset, then 1 issue with IS_rd=5 → ROB_name=0 before the edge and 1 after. CDB name=0, val=0x1234 → the next cycle gives commit_sgn=1, dest=5, value=0x1234, name=0.
- Issue 16 entries with no CDB → ROB_full=1 and count=16. A 17th IS_sgn is ignored and tail stays 0.
- Out-of-order CDB: entries 0, 1, 2 are issued; CDB writes 2, then 1, then 0 → commits occur in order 0, 1, 2 on consecutive cycles starting the cycle after entry 0 is written.
- Lookup bypass: ord1=3 is busy and not ready, with same-cycle CDB name=3, val=0xDEAD → ROB_rdy1=1 and ROB_val1=0xDEAD combinationally.
- Flush with 5 live entries plus a simultaneous issue → afterwards count=0, ROB_name=0, ROB_full=0, and no commit pulses.
- Wrap: 20 issue/commit pairs run back to back → head and tail wrap 15→0, and commit names run 0..15, 0..3 with no gaps.
- Hold: rdy=0 during a pending commit → no pulse and no pointer change; the commit occurs on the first edge after rdy=1.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared sizing and entry layout for the reorder buffer.
package rob_pkg;

  localparam int ROB_SIZE_DEF = 16;
  localparam int REG_W        = 5;
  localparam int DATA_W       = 32;

  typedef struct packed {
    logic              busy;
    logic              ready;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] value;
  } rob_entry_t;

  localparam rob_entry_t ENTRY_EMPTY = '{busy: 1'b0, ready: 1'b0, dest: '0, value: '0};

endpackage

// File: rtl/rob.sv
// Reorder buffer: allocates names at issue, captures CDB results, retires in
// program order and answers operand lookups with a same-cycle CDB bypass.
module rob
  import rob_pkg::*;
#(
  parameter int  ROB_SIZE = ROB_SIZE_DEF,
  localparam int IDX_W    = $clog2(ROB_SIZE),
  localparam int CNT_W    = IDX_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              IS_sgn,
  input  logic [REG_W-1:0]  IS_rd,
  output logic              ROB_full,
  output logic [IDX_W-1:0]  ROB_name,
  input  logic [IDX_W-1:0]  ROB_ord1,
  input  logic [IDX_W-1:0]  ROB_ord2,
  output logic              ROB_rdy1,
  output logic              ROB_rdy2,
  output logic [DATA_W-1:0] ROB_val1,
  output logic [DATA_W-1:0] ROB_val2,
  input  logic              CDB_sgn,
  input  logic [IDX_W-1:0]  CDB_name,
  input  logic [DATA_W-1:0] CDB_val,
  output logic              ROB_commit_sgn,
  output logic [REG_W-1:0]  ROB_commit_dest,
  output logic [DATA_W-1:0] ROB_commit_value,
  output logic [IDX_W-1:0]  ROB_commit_ROB_name
);

  rob_entry_t        ent_q [ROB_SIZE];
  rob_entry_t        ent_d [ROB_SIZE];
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              commit_sgn_q, commit_sgn_d;
  logic [REG_W-1:0]  commit_dest_q, commit_dest_d;
  logic [DATA_W-1:0] commit_value_q, commit_value_d;
  logic [IDX_W-1:0]  commit_name_q, commit_name_d;

  logic full;
  logic do_issue;
  logic do_commit;
  logic do_wb;

  // Full is judged on the start-of-cycle count: a slot freed by this cycle's
  // commit is not reusable until the next cycle.
  assign full      = (count_q == CNT_W'(ROB_SIZE));
  assign do_issue  = IS_sgn && !full;
  assign do_commit = ent_q[head_q].busy && ent_q[head_q].ready;
  assign do_wb     = CDB_sgn && ent_q[CDB_name].busy;

  always_comb begin
    ent_d          = ent_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_sgn_d   = 1'b0;
    commit_dest_d  = commit_dest_q;
    commit_value_d = commit_value_q;
    commit_name_d  = commit_name_q;

    if (rdy) begin
      if (clr) begin
        for (int i = 0; i < ROB_SIZE; i++) begin
          ent_d[i] = ENTRY_EMPTY;
        end
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (do_wb) begin
          ent_d[CDB_name].ready = 1'b1;
          ent_d[CDB_name].value = CDB_val;
        end

        if (do_commit) begin
          commit_sgn_d          = 1'b1;
          commit_dest_d         = ent_q[head_q].dest;
          commit_value_d        = ent_q[head_q].value;
          commit_name_d         = head_q;
          ent_d[head_q].busy    = 1'b0;
          ent_d[head_q].ready   = 1'b0;
          head_d                = head_q + IDX_W'(1);
        end

        if (do_issue) begin
          ent_d[tail_q] = '{busy: 1'b1, ready: 1'b0, dest: IS_rd, value: '0};
          tail_d        = tail_q + IDX_W'(1);
        end

        case ({do_issue, do_commit})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        ent_q[i] <= ENTRY_EMPTY;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_sgn_q   <= 1'b0;
      commit_dest_q  <= '0;
      commit_value_q <= '0;
      commit_name_q  <= '0;
    end else begin
      ent_q          <= ent_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_sgn_q   <= commit_sgn_d;
      commit_dest_q  <= commit_dest_d;
      commit_value_q <= commit_value_d;
      commit_name_q  <= commit_name_d;
    end
  end

  logic bypass1, bypass2;

  assign bypass1 = CDB_sgn && (CDB_name == ROB_ord1);
  assign bypass2 = CDB_sgn && (CDB_name == ROB_ord2);

  always_comb begin
    ROB_rdy1 = ent_q[ROB_ord1].busy && (ent_q[ROB_ord1].ready || bypass1);
    ROB_rdy2 = ent_q[ROB_ord2].busy && (ent_q[ROB_ord2].ready || bypass2);
    ROB_val1 = '0;
    ROB_val2 = '0;
    if (ROB_rdy1) ROB_val1 = bypass1 ? CDB_val : ent_q[ROB_ord1].value;
    if (ROB_rdy2) ROB_val2 = bypass2 ? CDB_val : ent_q[ROB_ord2].value;
  end

  assign ROB_full            = full;
  assign ROB_name            = tail_q;
  assign ROB_commit_sgn      = commit_sgn_q;
  assign ROB_commit_dest     = commit_dest_q;
  assign ROB_commit_value    = commit_value_q;
  assign ROB_commit_ROB_name = commit_name_q;

endmodule

// File: tb/tb_rob.sv
// Directed vector table plus hand sequences for full, flush and wrap cases.
module tb_rob;

  logic        clk = 1'b0;
  logic        rst, rdy, clr;
  logic        IS_sgn;
  logic [4:0]  IS_rd;
  logic        ROB_full;
  logic [3:0]  ROB_name;
  logic [3:0]  ROB_ord1, ROB_ord2;
  logic        ROB_rdy1, ROB_rdy2;
  logic [31:0] ROB_val1, ROB_val2;
  logic        CDB_sgn;
  logic [3:0]  CDB_name;
  logic [31:0] CDB_val;
  logic        ROB_commit_sgn;
  logic [4:0]  ROB_commit_dest;
  logic [31:0] ROB_commit_value;
  logic [3:0]  ROB_commit_ROB_name;

  int errors = 0;
  int checks = 0;

  rob dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .IS_sgn(IS_sgn), .IS_rd(IS_rd),
    .ROB_full(ROB_full), .ROB_name(ROB_name),
    .ROB_ord1(ROB_ord1), .ROB_ord2(ROB_ord2),
    .ROB_rdy1(ROB_rdy1), .ROB_rdy2(ROB_rdy2),
    .ROB_val1(ROB_val1), .ROB_val2(ROB_val2),
    .CDB_sgn(CDB_sgn), .CDB_name(CDB_name), .CDB_val(CDB_val),
    .ROB_commit_sgn(ROB_commit_sgn), .ROB_commit_dest(ROB_commit_dest),
    .ROB_commit_value(ROB_commit_value), .ROB_commit_ROB_name(ROB_commit_ROB_name)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, is_sgn;
    logic [4:0]  is_rd;
    logic        cdb_sgn;
    logic [3:0]  cdb_name;
    logic [31:0] cdb_val;
    logic [3:0]  ord1, ord2;
    logic        e_full;
    logic [3:0]  e_name;
    logic        e_rdy1;
    logic [31:0] e_val1;
    logic        e_rdy2;
    logic [31:0] e_val2;
    logic        e_csgn;
    logic [4:0]  e_cdest;
    logic [31:0] e_cval;
    logic [3:0]  e_cname;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic r, logic is, logic [4:0] rd, logic cs, logic [3:0] cn,
                             logic [31:0] cv, logic [3:0] o1, logic [3:0] o2,
                             logic ef, logic [3:0] en, logic er1, logic [31:0] ev1,
                             logic er2, logic [31:0] ev2, logic ec, logic [4:0] ecd,
                             logic [31:0] ecv, logic [3:0] ecn);
    vec_t t;
    t.rdy = r; t.is_sgn = is; t.is_rd = rd; t.cdb_sgn = cs; t.cdb_name = cn; t.cdb_val = cv;
    t.ord1 = o1; t.ord2 = o2; t.e_full = ef; t.e_name = en; t.e_rdy1 = er1; t.e_val1 = ev1;
    t.e_rdy2 = er2; t.e_val2 = ev2; t.e_csgn = ec; t.e_cdest = ecd; t.e_cval = ecv;
    t.e_cname = ecn;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; clr = 1'b0; IS_sgn = 1'b0; IS_rd = '0;
    CDB_sgn = 1'b0; CDB_name = '0; CDB_val = '0;
    ROB_ord1 = '0; ROB_ord2 = 4'd15;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd);
    idle_inputs();
    IS_sgn = 1'b1; IS_rd = rd;
    tick();
  endtask

  task automatic cdb(input logic [3:0] n, input logic [31:0] val);
    idle_inputs();
    CDB_sgn = 1'b1; CDB_name = n; CDB_val = val;
    tick();
  endtask

  initial begin
    // rdy is1 rd cs cn cval o1 o2 | full name r1 v1 r2 v2 | csgn cdest cval cname
    vecs.push_back(v(1,1,5,0,0,0,0,15,       0,0,0,0,0,0,          0,0,0,0));
    vecs.push_back(v(1,0,0,1,0,32'h1234,0,15,0,1,1,32'h1234,0,0,   0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,0,0,15,       0,1,1,32'h1234,0,0,   1,5,32'h1234,0));
    vecs.push_back(v(1,0,0,0,0,0,0,15,       0,1,0,0,0,0,          0,0,0,0));
    vecs.push_back(v(1,1,1,0,0,0,1,15,       0,1,0,0,0,0,          0,0,0,0));
    vecs.push_back(v(1,1,2,0,0,0,1,15,       0,2,0,0,0,0,          0,0,0,0));
    vecs.push_back(v(1,1,3,0,0,0,1,15,       0,3,0,0,0,0,          0,0,0,0));
    vecs.push_back(v(1,0,0,1,3,32'h33,3,1,   0,4,1,32'h33,0,0,     0,0,0,0));
    vecs.push_back(v(1,0,0,1,2,32'h22,3,2,   0,4,1,32'h33,1,32'h22,0,0,0,0));
    vecs.push_back(v(1,0,0,1,1,32'h11,1,2,   0,4,1,32'h11,1,32'h22,0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,0,1,3,        0,4,1,32'h11,1,32'h33,1,1,32'h11,1));
    vecs.push_back(v(1,0,0,0,0,0,1,3,        0,4,0,0,1,32'h33,     1,2,32'h22,2));
    vecs.push_back(v(1,0,0,0,0,0,1,3,        0,4,0,0,1,32'h33,     1,3,32'h33,3));
    vecs.push_back(v(1,0,0,0,0,0,3,15,       0,4,0,0,0,0,          0,0,0,0));
    vecs.push_back(v(1,1,0,0,0,0,4,15,       0,4,0,0,0,0,          0,0,0,0));
    vecs.push_back(v(1,0,0,1,4,32'h77,4,15,  0,5,1,32'h77,0,0,     0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,0,4,15,       0,5,1,32'h77,0,0,     1,0,32'h77,4));
    vecs.push_back(v(1,0,0,1,9,32'h99,9,15,  0,5,0,0,0,0,          0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,0,9,15,       0,5,0,0,0,0,          0,0,0,0));
    vecs.push_back(v(1,1,6,0,0,0,5,15,       0,5,0,0,0,0,          0,0,0,0));
    vecs.push_back(v(1,0,0,1,5,32'h55,5,15,  0,6,1,32'h55,0,0,     0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,5,15,       0,6,1,32'h55,0,0,     0,0,0,0));
    vecs.push_back(v(0,1,7,0,0,0,5,15,       0,6,1,32'h55,0,0,     0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,0,5,15,       0,6,1,32'h55,0,0,     1,6,32'h55,5));
    vecs.push_back(v(1,0,0,0,0,0,5,15,       0,6,0,0,0,0,          0,0,0,0));

    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    ROB_ord1 = 4'd0;
    #1;
    chk("reset_commit_sgn", ROB_commit_sgn, 0);
    chk("reset_name", ROB_name, 0);
    chk("reset_full", ROB_full, 0);
    chk("reset_rdy1", ROB_rdy1, 0);

    foreach (vecs[i]) begin
      rdy = vecs[i].rdy; clr = 1'b0;
      IS_sgn = vecs[i].is_sgn; IS_rd = vecs[i].is_rd;
      CDB_sgn = vecs[i].cdb_sgn; CDB_name = vecs[i].cdb_name; CDB_val = vecs[i].cdb_val;
      ROB_ord1 = vecs[i].ord1; ROB_ord2 = vecs[i].ord2;
      #1;
      chk($sformatf("v%0d_full", i), ROB_full, vecs[i].e_full);
      chk($sformatf("v%0d_name", i), ROB_name, vecs[i].e_name);
      chk($sformatf("v%0d_rdy1", i), ROB_rdy1, vecs[i].e_rdy1);
      chk($sformatf("v%0d_val1", i), ROB_val1, vecs[i].e_val1);
      chk($sformatf("v%0d_rdy2", i), ROB_rdy2, vecs[i].e_rdy2);
      chk($sformatf("v%0d_val2", i), ROB_val2, vecs[i].e_val2);
      tick();
      chk($sformatf("v%0d_commit_sgn", i), ROB_commit_sgn, vecs[i].e_csgn);
      if (vecs[i].e_csgn) begin
        chk($sformatf("v%0d_commit_dest", i), ROB_commit_dest, vecs[i].e_cdest);
        chk($sformatf("v%0d_commit_value", i), ROB_commit_value, vecs[i].e_cval);
        chk($sformatf("v%0d_commit_name", i), ROB_commit_ROB_name, vecs[i].e_cname);
      end
    end

    // Fill to capacity, overflow attempt, then commit with a blocked issue.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fill_name_%0d", i), ROB_name, i);
      chk($sformatf("fill_notfull_%0d", i), ROB_full, 0);
      issue(5'(i + 1));
    end
    chk("full_after_16", ROB_full, 1);
    chk("full_tail_wrapped", ROB_name, 0);
    issue(5'd31);
    chk("overflow_ignored_name", ROB_name, 0);
    chk("overflow_still_full", ROB_full, 1);
    cdb(4'd0, 32'hA0);
    chk("full_cdb_no_commit_yet", ROB_commit_sgn, 0);
    issue(5'd30);
    chk("full_commit_sgn", ROB_commit_sgn, 1);
    chk("full_commit_name", ROB_commit_ROB_name, 0);
    chk("full_commit_dest", ROB_commit_dest, 1);
    chk("full_commit_value", ROB_commit_value, 32'hA0);
    chk("full_issue_blocked_name", ROB_name, 0);
    chk("full_after_commit", ROB_full, 0);
    issue(5'd29);
    chk("refill_name", ROB_name, 1);
    chk("refill_full", ROB_full, 1);

    // Lookup bypass and flush with live entries plus a simultaneous issue.
    do_reset();
    for (int i = 0; i < 5; i++) issue(5'(i + 1));
    idle_inputs();
    ROB_ord1 = 4'd3; CDB_sgn = 1'b1; CDB_name = 4'd3; CDB_val = 32'hDEAD;
    #1;
    chk("bypass_rdy1", ROB_rdy1, 1);
    chk("bypass_val1", ROB_val1, 32'hDEAD);
    tick();
    cdb(4'd0, 32'h10);
    idle_inputs();
    clr = 1'b1; IS_sgn = 1'b1; IS_rd = 5'd9;
    tick();
    chk("flush_commit_sgn", ROB_commit_sgn, 0);
    chk("flush_name", ROB_name, 0);
    chk("flush_full", ROB_full, 0);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      ROB_ord1 = 4'd3; ROB_ord2 = 4'd0;
      #1;
      chk($sformatf("flush_rdy1_%0d", i), ROB_rdy1, 0);
      chk($sformatf("flush_rdy2_%0d", i), ROB_rdy2, 0);
      tick();
      chk($sformatf("flush_no_pulse_%0d", i), ROB_commit_sgn, 0);
    end

    // Twenty issue/writeback/commit rounds across the pointer wrap.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("wrap_name_%0d", k), ROB_name, k % 16);
      issue(5'((k % 31) + 1));
      chk($sformatf("wrap_no_pulse_a_%0d", k), ROB_commit_sgn, 0);
      cdb(4'(k % 16), 32'(k + 32'h100));
      chk($sformatf("wrap_no_pulse_b_%0d", k), ROB_commit_sgn, 0);
      idle_inputs();
      tick();
      chk($sformatf("wrap_commit_sgn_%0d", k), ROB_commit_sgn, 1);
      chk($sformatf("wrap_commit_name_%0d", k), ROB_commit_ROB_name, k % 16);
      chk($sformatf("wrap_commit_dest_%0d", k), ROB_commit_dest, (k % 31) + 1);
      chk($sformatf("wrap_commit_value_%0d", k), ROB_commit_value, k + 32'h100);
    end
    chk("wrap_end_name", ROB_name, 4);
    chk("wrap_end_full", ROB_full, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
